sort_ctrl: RTL and testbench
============================

// Module: sort_ctrl
// PURPOSE
//  Front-end sequencer for the nibble sort engine on the board. Debounces key1 (insert)
//  and key2 (sort) into single-cycle commands, latches sw as insert data, counts stored
//  elements, and issues insert/start/clear to the engine with a busy handshake and timeout.
//  It sits between the board I/O and the sort datapath. Status goes to spare LEDs.
// PARAMETERS
//  W        4     element width (bits), equals sw width
//  DEPTH    4     engine capacity (elements); CNT_W = $clog2(DEPTH+1)
//  DEB      16    cycles a raw key level must hold before it is accepted (>=2)
//  TIMEOUT  1024  max cycles to wait for eng_busy to fall after eng_start
// PORTS
//  clk        in   1      system clock, all logic on rising edge
//  rst        in   1      synchronous, active-high reset
//  key1       in   1      raw insert key, active-high, asynchronous to clk
//  key2       in   1      raw sort key, active-high, asynchronous to clk
//  sw         in   W      insert data, sampled on the accepted key1 edge
//  eng_ins    out  1      one-cycle insert strobe to engine
//  eng_data   out  W      insert data, valid while eng_ins=1
//  eng_start  out  1      one-cycle sort start strobe
//  eng_clear  out  1      one-cycle engine clear strobe
//  eng_busy   in   1      engine sorting; sampled from the cycle after eng_start
//  count      out  CNT_W  elements currently stored
//  full       out  1      count==DEPTH
//  sorted     out  1      last sort completed, contents unchanged since
//  err        out  1      one-cycle pulse: insert when full, or sort timeout
// BEHAVIOUR
//  Reset: every output 0; FSM=IDLE; debouncers cleared (debounced level 0).
//  Input path: 2-flop synchroniser per key, then debouncer; debounced 0->1 gives a one-cycle
//   cmd pulse. Key press to cmd pulse = 2 + DEB cycles. Holding a key gives exactly one pulse.
//  FSM states: IDLE, INS, START, WAIT, DONE, CLR.
//  IDLE: ins_cmd & !full -> INS; eng_data<=sw. ins_cmd & full -> err pulse, stay in IDLE.
//   sort_cmd & count>=2 -> START. sort_cmd & count<2 -> DONE, no eng_start, sorted<=1.
//  INS: eng_ins=1 for one cycle, count<=count+1; next IDLE. sorted<=0.
//  START: eng_start=1 for one cycle; timer<=0; next WAIT.
//  WAIT: timer increments each cycle. !eng_busy with timer>=1 -> DONE, sorted<=1.
//   timer==TIMEOUT-1 with eng_busy still 1 -> err pulse, IDLE, sorted stays 0.
//  DONE: sort_cmd -> START again (re-sort allowed). ins_cmd -> CLR.
//  CLR: eng_clear=1 for one cycle, count<=0, sorted<=0. Then INS with the eng_data latched on
//   the key edge. So a new batch starts with the pressed value.
//  Simultaneous cmds in one cycle: sort_cmd wins and ins_cmd is dropped. No err for the drop.
//  Cmds arriving in INS/START/WAIT/CLR are dropped silently. No queueing.
//  count saturates at DEPTH and never wraps; full is combinational from count.
//  rst in any state, including WAIT: return to reset values the next cycle. No eng_clear is
//   issued; the engine shares rst and clears itself.
//  Arithmetic: count and timer unsigned; timer width $clog2(TIMEOUT).
// STRUCTURE
//  sort_pkg: state enum (IDLE..CLR), default W/DEPTH constants.
//  Sub-module key_debounce (sync + stability counter + rising-edge pulse), instantiated twice.
//  Parameter: DEB. Ports: clk, rst, raw, level, pulse.
//  sort_ctrl: FSM, data latch, counter, timeout timer.
// TESTING (DEB=4, TIMEOUT=32 in bench)
//  Hold key1 10 cycles with sw=4'b1001 -> exactly one eng_ins with eng_data=1001 and count=1.
//   A 2-cycle glitch on key1 gives no eng_ins.
//  Insert 1111,1001,0110,0011 -> count=4, full=1. Fifth key1 -> err pulse, no eng_ins,
//   count stays 4.
//  key2 with count=4 and busy held 5 cycles -> one eng_start, sorted=1 the cycle after busy
//   falls. With count=1, key2 -> sorted=1 and no eng_start.
//  Busy stuck high after eng_start -> err 32 cycles later, FSM in IDLE, sorted=0.
//  In DONE, key1 with sw=0101 -> eng_clear, then eng_ins 0101 next cycle, count=1, sorted=0.
//  key1 and key2 accepted in the same cycle -> only eng_start. rst asserted in WAIT -> all
//   outputs 0 the next cycle.

Source files
------------

// File: rtl/sort_pkg.sv
// Shared types and defaults for the nibble sort front-end.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package sort_pkg;

  localparam int W_DEF     = 4;
  localparam int DEPTH_DEF = 4;

  // Sequencer states. IDLE is the reset state.
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    INS   = 3'd1,
    START = 3'd2,
    WAIT  = 3'd3,
    DONE  = 3'd4,
    CLR   = 3'd5
  } state_e;

endpackage

// File: rtl/key_debounce.sv
// Key conditioner: 2-flop synchroniser, stability counter, rising-edge command pulse.
// Latency: raw edge to level/pulse = 2 + DEB cycles; a held key gives exactly one pulse.
// Backpressure: none; a pulse is a one-cycle event and is never held or queued.
module key_debounce #(
  parameter int DEB = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic level,
  output logic pulse
);

  // Counter only has to reach DEB-1, so $clog2(DEB) bits are enough (DEB >= 2).
  localparam int CW = $clog2(DEB);

  logic          s1_q, s2_q;
  logic          level_q, level_d;
  logic          pulse_q, pulse_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // Accept a new level only after the synchronised input has disagreed with the
  // current level for DEB consecutive samples; any bounce restarts the count.
  always_comb begin
    level_d = level_q;
    pulse_d = 1'b0;
    cnt_d   = '0;
    if (s2_q != level_q) begin
      if (cnt_q == CW'(DEB - 1)) begin
        level_d = s2_q;
        pulse_d = s2_q;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  // Synchroniser and debounce state.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q    <= 1'b0;
      s2_q    <= 1'b0;
      level_q <= 1'b0;
      pulse_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      s1_q    <= raw;
      s2_q    <= s1_q;
      level_q <= level_d;
      pulse_q <= pulse_d;
      cnt_q   <= cnt_d;
    end
  end

  assign level = level_q;
  assign pulse = pulse_q;

endmodule

// File: rtl/sort_ctrl.sv
// Front-end sequencer: turns debounced key commands into insert/start/clear strobes for the sort engine.
// Latency: key press to engine strobe = 3 + DEB cycles; a sort waits up to TIMEOUT cycles on eng_busy.
// Backpressure: commands arriving while a strobe or sort is in flight are dropped, never queued.
module sort_ctrl
  import sort_pkg::*;
#(
  parameter int  W       = W_DEF,
  parameter int  DEPTH   = DEPTH_DEF,
  parameter int  DEB     = 16,
  parameter int  TIMEOUT = 1024,
  localparam int CNT_W   = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             key1,
  input  logic             key2,
  input  logic [W-1:0]     sw,
  output logic             eng_ins,
  output logic [W-1:0]     eng_data,
  output logic             eng_start,
  output logic             eng_clear,
  input  logic             eng_busy,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             sorted,
  output logic             err
);

  localparam int TW = $clog2(TIMEOUT);

  logic ins_cmd, sort_cmd;
  logic key1_lvl, key2_lvl;
  logic unused_lvl;

  state_e           state_q, state_d;
  logic [W-1:0]     data_q, data_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             sorted_q, sorted_d;
  logic [TW-1:0]    timer_q, timer_d;
  logic             err_c;

  key_debounce #(.DEB(DEB)) u_key1 (
    .clk   (clk),
    .rst   (rst),
    .raw   (key1),
    .level (key1_lvl),
    .pulse (ins_cmd)
  );

  key_debounce #(.DEB(DEB)) u_key2 (
    .clk   (clk),
    .rst   (rst),
    .raw   (key2),
    .level (key2_lvl),
    .pulse (sort_cmd)
  );

  // Only the edge pulses drive the sequencer; the held levels are not needed here.
  assign unused_lvl = key1_lvl ^ key2_lvl;

  // Sequencer next state. sort_cmd has priority over ins_cmd in every state that listens.
  always_comb begin
    state_d  = state_q;
    data_d   = data_q;
    count_d  = count_q;
    sorted_d = sorted_q;
    timer_d  = timer_q;
    err_c    = 1'b0;
    case (state_q)
      IDLE: begin
        if (sort_cmd) begin
          if (count_q >= CNT_W'(2)) begin
            state_d = START;
          end else begin
            // Zero or one element is already in order: report sorted without the engine.
            state_d  = DONE;
            sorted_d = 1'b1;
          end
        end else if (ins_cmd) begin
          if (full) begin
            err_c = 1'b1;
          end else begin
            data_d  = sw;
            state_d = INS;
          end
        end
      end
      INS: begin
        if (count_q != CNT_W'(DEPTH)) begin
          count_d = count_q + CNT_W'(1);
        end
        sorted_d = 1'b0;
        state_d  = IDLE;
      end
      START: begin
        timer_d  = '0;
        sorted_d = 1'b0;
        state_d  = WAIT;
      end
      WAIT: begin
        timer_d = timer_q + TW'(1);
        // The engine gets one cycle to raise busy, so a low busy at timer 0 is ignored.
        if (!eng_busy && (timer_q != '0)) begin
          state_d  = DONE;
          sorted_d = 1'b1;
        end else if (timer_q == TW'(TIMEOUT - 1)) begin
          err_c   = 1'b1;
          state_d = IDLE;
        end
      end
      DONE: begin
        if (sort_cmd) begin
          state_d = START;
        end else if (ins_cmd) begin
          // A key1 after a sort starts a new batch, seeded with the value on the switches now.
          data_d  = sw;
          state_d = CLR;
        end
      end
      CLR: begin
        count_d  = '0;
        sorted_d = 1'b0;
        state_d  = INS;
      end
      default: state_d = IDLE;
    endcase
  end

  // Sequencer state, data latch, element counter and sort timer.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      data_q   <= '0;
      count_q  <= '0;
      sorted_q <= 1'b0;
      timer_q  <= '0;
    end else begin
      state_q  <= state_d;
      data_q   <= data_d;
      count_q  <= count_d;
      sorted_q <= sorted_d;
      timer_q  <= timer_d;
    end
  end

  assign eng_ins   = (state_q == INS);
  assign eng_start = (state_q == START);
  assign eng_clear = (state_q == CLR);
  assign eng_data  = data_q;
  assign count     = count_q;
  assign full      = (count_q == CNT_W'(DEPTH));
  assign sorted    = sorted_q;
  assign err       = err_c;

endmodule

// File: tb/tb_sort_ctrl.sv
module tb_sort_ctrl;

  logic       clk = 1'b0;
  logic       rst, key1, key2;
  logic [3:0] sw;
  logic       eng_ins, eng_start, eng_clear, full, sorted, err;
  logic [3:0] eng_data;
  logic [2:0] count;
  logic       eng_busy = 1'b0;

  sort_ctrl #(.W(4), .DEPTH(4), .DEB(4), .TIMEOUT(32)) dut (
    .clk(clk), .rst(rst), .key1(key1), .key2(key2), .sw(sw),
    .eng_ins(eng_ins), .eng_data(eng_data), .eng_start(eng_start),
    .eng_clear(eng_clear), .eng_busy(eng_busy), .count(count),
    .full(full), .sorted(sorted), .err(err)
  );

  initial forever #5 clk = ~clk;

  // Engine stand-in: busy rises the cycle after eng_start and stays up busy_len cycles.
  int   busy_len = 3;
  int   busy_rem = 0;
  logic stuck    = 1'b0;
  always @(posedge clk) begin
    #1;
    if (rst) begin
      busy_rem = 0;
      eng_busy = 1'b0;
    end else begin
      eng_busy = stuck || (busy_rem > 0);
      if (busy_rem > 0) busy_rem--;
      if (eng_start) busy_rem = busy_len;
    end
  end

  int n_cmp = 0, n_bad = 0;
  int cyc = 0, n_ins = 0, n_start = 0, n_clr = 0, n_err = 0;
  logic [3:0] last_data = 4'h0;

  // Reference model: stored elements, whether the last command was a sort, sorted flag.
  logic [3:0] m_list[$];
  bit         m_done   = 0;
  bit         m_sorted = 0;

  // One clock cycle; outputs are observed on the falling edge.
  task automatic step();
    @(negedge clk);
    cyc++;
    if (eng_ins) begin n_ins++; last_data = eng_data; end
    if (eng_start) n_start++;
    if (eng_clear) n_clr++;
    if (err) n_err++;
  endtask

  task automatic press(input logic k1, input logic k2, input int hold);
    key1 = k1; key2 = k2;
    repeat (hold) step();
    key1 = 1'b0; key2 = 1'b0;
    repeat (14) step();
  endtask

  task automatic do_reset();
    rst = 1'b1; key1 = 1'b0; key2 = 1'b0; stuck = 1'b0;
    repeat (2) step();
    rst = 1'b0;
    step();
    m_list.delete(); m_done = 0; m_sorted = 0;
  endtask

  task automatic do_insert(input logic [3:0] v);
    int i0, e0, c0, exp_ins, exp_err, exp_clr;
    i0 = n_ins; e0 = n_err; c0 = n_clr;
    exp_clr = m_done ? 1 : 0;
    exp_err = (!m_done && m_list.size() == 4) ? 1 : 0;
    exp_ins = 1 - exp_err;
    if (m_done) begin m_list.delete(); m_done = 0; end
    if (exp_ins == 1) begin m_list.push_back(v); m_sorted = 0; end
    sw = v;
    press(1'b1, 1'b0, 10);
    n_cmp++; if (n_ins - i0 != exp_ins) begin n_bad++; $display("FAIL ins_strobes v=%h got %0d want %0d", v, n_ins - i0, exp_ins); end
    n_cmp++; if (n_err - e0 != exp_err) begin n_bad++; $display("FAIL ins_err v=%h got %0d want %0d", v, n_err - e0, exp_err); end
    n_cmp++; if (n_clr - c0 != exp_clr) begin n_bad++; $display("FAIL ins_clear v=%h got %0d want %0d", v, n_clr - c0, exp_clr); end
    if (exp_ins == 1) begin
      n_cmp++; if (last_data !== v) begin n_bad++; $display("FAIL ins_data got %h want %h", last_data, v); end
    end
    n_cmp++; if (int'(count) != m_list.size()) begin n_bad++; $display("FAIL ins_count got %0d want %0d", count, m_list.size()); end
    n_cmp++; if (full !== (m_list.size() == 4)) begin n_bad++; $display("FAIL ins_full got %b want %b", full, m_list.size() == 4); end
    n_cmp++; if (sorted !== m_sorted) begin n_bad++; $display("FAIL ins_sorted got %b want %b", sorted, m_sorted); end
  endtask

  task automatic do_sort(input int len);
    int s0, exp_start;
    s0 = n_start;
    exp_start = (m_list.size() >= 2) ? 1 : 0;
    busy_len = len;
    press(1'b0, 1'b1, 10);
    m_done = 1; m_sorted = 1;
    n_cmp++; if (n_start - s0 != exp_start) begin n_bad++; $display("FAIL sort_start n=%0d got %0d want %0d", m_list.size(), n_start - s0, exp_start); end
    n_cmp++; if (sorted !== 1'b1) begin n_bad++; $display("FAIL sort_sorted got %b want 1", sorted); end
    n_cmp++; if (int'(count) != m_list.size()) begin n_bad++; $display("FAIL sort_count got %0d want %0d", count, m_list.size()); end
  endtask

  task automatic test_reset();
    rst = 1'b1; key1 = 1'b0; key2 = 1'b0; sw = 4'hF;
    repeat (3) step();
    n_cmp++; if ({eng_ins, eng_start, eng_clear, err} !== 4'b0) begin n_bad++; $display("FAIL rst_strobes got %b want 0000", {eng_ins, eng_start, eng_clear, err}); end
    n_cmp++; if (eng_data !== 4'h0) begin n_bad++; $display("FAIL rst_data got %h want 0", eng_data); end
    n_cmp++; if ({count, full, sorted} !== 5'b0) begin n_bad++; $display("FAIL rst_status got %b want 00000", {count, full, sorted}); end
    rst = 1'b0;
    repeat (3) step();
    n_cmp++; if ({eng_ins, eng_start, eng_clear, err, count} !== 7'b0) begin n_bad++; $display("FAIL rst_idle got %b want 0", {eng_ins, eng_start, eng_clear, err, count}); end
  endtask

  task automatic test_glitch();
    int i0;
    do_reset();
    i0 = n_ins; sw = 4'hA;
    press(1'b1, 1'b0, 2);
    n_cmp++; if (n_ins != i0) begin n_bad++; $display("FAIL glitch_ins got %0d want 0", n_ins - i0); end
    n_cmp++; if (count !== 3'd0) begin n_bad++; $display("FAIL glitch_count got %0d want 0", count); end
  endtask

  task automatic test_insert_hold();
    do_reset();
    do_insert(4'b1001);
  endtask

  task automatic test_fill();
    do_reset();
    do_insert(4'b1111); do_insert(4'b1001); do_insert(4'b0110); do_insert(4'b0011);
    do_insert(4'b1010);
  endtask

  task automatic test_sort_busy();
    int s0, t_start, t_fall;
    s0 = n_start; t_start = -1; t_fall = -1;
    busy_len = 5;
    key2 = 1'b1;
    for (int i = 0; i < 40; i++) begin
      step();
      if (i == 9) key2 = 1'b0;
      if (eng_start && t_start < 0) t_start = cyc;
      if (t_fall >= 0 && cyc == t_fall + 1) begin
        n_cmp++; if (sorted !== 1'b1) begin n_bad++; $display("FAIL sorted_after_fall got %b want 1", sorted); end
      end
      if (t_start >= 0 && t_fall < 0 && cyc > t_start + 1 && !eng_busy) begin
        t_fall = cyc;
        n_cmp++; if (sorted !== 1'b0) begin n_bad++; $display("FAIL sorted_at_fall got %b want 0", sorted); end
      end
    end
    m_done = 1; m_sorted = 1;
    n_cmp++; if (n_start - s0 != 1) begin n_bad++; $display("FAIL busy_starts got %0d want 1", n_start - s0); end
    n_cmp++; if (t_fall < 0) begin n_bad++; $display("FAIL busy_fall_seen got %0d want >=0", t_fall); end
  endtask

  task automatic test_sort_small();
    do_reset();
    do_insert(4'h7);
    do_sort(3);
  endtask

  task automatic test_timeout();
    int t_start, t_err, e0;
    do_reset();
    do_insert(4'h3); do_insert(4'hC);
    stuck = 1'b1; t_start = -1; t_err = -1; e0 = n_err;
    key2 = 1'b1;
    for (int i = 0; i < 60; i++) begin
      step();
      if (i == 9) key2 = 1'b0;
      if (eng_start && t_start < 0) t_start = cyc;
      if (err && t_err < 0) begin
        t_err = cyc;
        n_cmp++; if (sorted !== 1'b0) begin n_bad++; $display("FAIL timeout_sorted got %b want 0", sorted); end
      end
    end
    stuck = 1'b0;
    repeat (3) step();
    n_cmp++; if (t_start < 0 || t_err - t_start != 32) begin n_bad++; $display("FAIL timeout_delay got %0d want 32", t_err - t_start); end
    n_cmp++; if (n_err - e0 != 1) begin n_bad++; $display("FAIL timeout_errs got %0d want 1", n_err - e0); end
    m_done = 0; m_sorted = 0;
    do_insert(4'h9);
  endtask

  task automatic test_done_clear();
    int t_clr, t_ins;
    logic [3:0] d_ins;
    do_reset();
    do_insert(4'h8); do_insert(4'h2);
    do_sort(3);
    t_clr = -1; t_ins = -1; d_ins = 4'h0;
    sw = 4'b0101; key1 = 1'b1;
    for (int i = 0; i < 30; i++) begin
      step();
      if (i == 9) key1 = 1'b0;
      if (eng_clear && t_clr < 0) t_clr = cyc;
      if (eng_ins && t_ins < 0) begin t_ins = cyc; d_ins = eng_data; end
    end
    m_list.delete(); m_list.push_back(4'b0101); m_done = 0; m_sorted = 0;
    n_cmp++; if (t_clr < 0 || t_ins != t_clr + 1) begin n_bad++; $display("FAIL clr_then_ins clr@%0d ins@%0d want ins one cycle after clr", t_clr, t_ins); end
    n_cmp++; if (d_ins !== 4'b0101) begin n_bad++; $display("FAIL clr_ins_data got %h want 5", d_ins); end
    n_cmp++; if (count !== 3'd1) begin n_bad++; $display("FAIL clr_count got %0d want 1", count); end
    n_cmp++; if (sorted !== 1'b0) begin n_bad++; $display("FAIL clr_sorted got %b want 0", sorted); end
  endtask

  task automatic test_simultaneous();
    int s0, i0, e0;
    do_reset();
    do_insert(4'h4); do_insert(4'h1);
    s0 = n_start; i0 = n_ins; e0 = n_err;
    busy_len = 4; sw = 4'hE;
    press(1'b1, 1'b1, 10);
    m_done = 1; m_sorted = 1;
    n_cmp++; if (n_start - s0 != 1) begin n_bad++; $display("FAIL simul_start got %0d want 1", n_start - s0); end
    n_cmp++; if (n_ins - i0 != 0) begin n_bad++; $display("FAIL simul_ins got %0d want 0", n_ins - i0); end
    n_cmp++; if (n_err - e0 != 0) begin n_bad++; $display("FAIL simul_err got %0d want 0", n_err - e0); end
    n_cmp++; if ({count, sorted} !== {3'd2, 1'b1}) begin n_bad++; $display("FAIL simul_status got %0d/%b want 2/1", count, sorted); end
  endtask

  task automatic test_rst_wait();
    int k;
    do_reset();
    do_insert(4'h6); do_insert(4'hB);
    stuck = 1'b1; key2 = 1'b1; k = 0;
    while (!eng_start && k < 30) begin step(); k++; end
    n_cmp++; if (!eng_start) begin n_bad++; $display("FAIL rstwait_start got 0 want 1 within 30 cycles"); end
    repeat (3) step();
    rst = 1'b1;
    step();
    n_cmp++; if ({eng_ins, eng_data, eng_start, eng_clear, count, full, sorted, err} !== 13'b0) begin
      n_bad++; $display("FAIL rstwait_outputs got %b want 0", {eng_ins, eng_data, eng_start, eng_clear, count, full, sorted, err});
    end
    key2 = 1'b0; stuck = 1'b0;
    repeat (3) step();
    rst = 1'b0;
    step();
    m_list.delete(); m_done = 0; m_sorted = 0;
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 24; i++) begin
      if ($urandom_range(0, 3) == 0) do_sort(int'($urandom_range(1, 8)));
      else do_insert(4'($urandom_range(0, 15)));
    end
  endtask

  initial begin
    rst = 1'b1; key1 = 1'b0; key2 = 1'b0; sw = 4'h0;
    test_reset();
    test_glitch();
    test_insert_hold();
    test_fill();
    test_sort_busy();
    test_sort_small();
    test_timeout();
    test_done_clear();
    test_simultaneous();
    test_rst_wait();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
